// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP. Misaligned and out-of-range accesses never reach memory.
module dmem_arbiter #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic [1:0]  fsm_state
);

   // Handshake: a requester raises req with we/addr/wdata stable and holds them
   // until it sees its one-cycle ack (registered, in RESP); it may drop or change
   // req only at the end of that RESP cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        gnt, gnt_nxt;
   logic        last;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        bad;

   assign fsm_state = state;

   always_comb begin
      sel_we    = gnt ? we1    : we0;
      sel_addr  = gnt ? addr1  : addr0;
      sel_wdata = gnt ? wdata1 : wdata0;
      // Full 30-bit word-index compare so high address bits cannot alias into range.
      bad       = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      mem_a     = 32'h0;
      mem_wd    = 32'h0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               gnt_nxt   = ~last;
               state_nxt = ACCESS;
            end else if (req0) begin
               gnt_nxt   = 1'b0;
               state_nxt = ACCESS;
            end else if (req1) begin
               gnt_nxt   = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            mem_a     = sel_addr;
            mem_wd    = sel_wdata;
            mem_we    = sel_we && !bad;
            state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         last   <= 1'b1;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= 32'h0;
         rdata1 <= 32'h0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
         if (state == ACCESS) begin
            last <= gnt;
            if (!gnt) begin
               ack0 <= 1'b1;
               err0 <= bad;
               if (bad)          rdata0 <= 32'h0;
               else if (!sel_we) rdata0 <= mem_rd;
            end else begin
               ack1 <= 1'b1;
               err1 <= bad;
               if (bad)          rdata1 <= 32'h0;
               else if (!sel_we) rdata1 <= mem_rd;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses with expected responses queued per port
// and checked by a negedge monitor against a behavioural dmem.
module tb_dmem_arbiter;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req0, we0, ack0, err0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        req1, we1, ack1, err1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;
   logic [1:0]  fsm_state;

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .fsm_state(fsm_state)
   );

   // clock / reset / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural dmem with a backdoor preload port
   logic [31:0] mem [0:DEPTH-1];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_idx = '0;
   logic [31:0] bd_data = '0;
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) begin
      if (mem_we)     mem[mem_a[7:2]] <= mem_wd;
      else if (bd_we) mem[bd_idx]     <= bd_data;
   end

   // scoreboard
   int          checks = 0;
   int          failures = 0;
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int          ack_port_q[$];
   int          ack_cyc_q[$];
   logic [32:0] exp_e0, exp_e1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=missing expected=present", name);
   endtask

   // monitor
   always @(negedge clk) begin
      if (ack0 && ack1) fail_now("ack_exclusive");
      if (ack0) begin
         ack_port_q.push_back(0);
         ack_cyc_q.push_back(cyc);
         if (exp_q0.size() == 0) fail_now("ack0_expected_entry");
         else begin
            exp_e0 = exp_q0.pop_front();
            check("p0_resp_err_data", {err0, rdata0}, exp_e0);
         end
      end
      if (ack1) begin
         ack_port_q.push_back(1);
         ack_cyc_q.push_back(cyc);
         if (exp_q1.size() == 0) fail_now("ack1_expected_entry");
         else begin
            exp_e1 = exp_q1.pop_front();
            check("p1_resp_err_data", {err1, rdata1}, exp_e1);
         end
      end
   end

   // driver tasks
   task automatic drive(input int port, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (port == 0) begin
         req0 = req; we0 = we; addr0 = addr; wdata0 = wd;
      end else begin
         req1 = req; we1 = we; addr1 = addr; wdata1 = wd;
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] data);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_idx = 6'(idx); bd_data = data;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // Uncontended access: checks the ACCESS-cycle memory drive and the 2-cycle ack latency.
   task automatic single(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
      logic exp_we;
      int   s;
      bit   got;
      exp_we = we && !exp_err;
      if (port == 0) exp_q0.push_back({exp_err, exp_rd});
      else           exp_q1.push_back({exp_err, exp_rd});
      @(posedge clk); #1;
      drive(port, 1'b1, we, addr, wd);
      s = cyc;
      @(negedge clk);
      check("idle_mem_we", mem_we, 1'b0);
      @(negedge clk);
      check("access_mem_we", mem_we, exp_we);
      check("access_mem_a", mem_a, addr);
      check("access_mem_wd", mem_wd, wd);
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if ((port == 0) ? ack0 : ack1) got = 1'b1;
      end
      if (got) check("ack_latency", 64'(cyc - s), 64'd2);
      else     fail_now("ack_within_budget");
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic check_log(input string name, input int idx, input int port, input int c);
      if (idx < ack_port_q.size()) begin
         check({name, "_port"}, 64'(ack_port_q[idx]), 64'(port));
         check({name, "_cycle"}, 64'(ack_cyc_q[idx]), 64'(c));
      end else fail_now({name, "_entry"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      resetn = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", fsm_state, 2'd0);
      check("rst_acks_errs", {ack0, ack1, err0, err1}, 4'b0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
      check("rst_mem_we", mem_we, 1'b0);
      preload(4, 32'h0000_0004);
      preload(8, 32'hCAFE_0008);
      preload(10, 32'h0A0A_0A0A);
      preload(11, 32'h0B0B_0B0B);
      preload(63, 32'h6363_6363);
      @(posedge clk); #1 resetn = 1'b1;

      // write then cross-port read, read data held
      single(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
      check("mem_word4_written", mem[4], 32'hDEAD_BEEF);
      single(1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      check("rdata1_hold_idle", rdata1, 32'hDEAD_BEEF);
      single(0, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h6363_6363);
      check("rdata1_hold_other_port", rdata1, 32'hDEAD_BEEF);

      // rejected accesses and range boundaries
      single(0, 1'b1, 32'h12, 32'h5555_5555, 1'b1, 32'h0);
      check("mem_word4_after_misaligned", mem[4], 32'hDEAD_BEEF);
      single(1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
      single(1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h6363_6363);
      single(1, 1'b1, 32'h4000_0010, 32'h7777_7777, 1'b1, 32'h0);
      check("mem_word4_after_high_addr", mem[4], 32'hDEAD_BEEF);
      single(0, 1'b0, 32'h4000_0028, 32'h0, 1'b1, 32'h0);

      // fairness from reset: both requests held high
      do_reset();
      ack_port_q.delete();
      ack_cyc_q.delete();
      exp_q0.push_back({1'b0, 32'h0A0A_0A0A});
      exp_q1.push_back({1'b0, 32'h0B0B_0B0B});
      exp_q0.push_back({1'b0, 32'h0A0A_0A0A});
      exp_q1.push_back({1'b0, 32'h0B0B_0B0B});
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h28, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h2C, 32'h0);
      s = cyc;
      repeat (12) @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("fair_ack_count", 64'(ack_port_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) check_log("fair", i, i % 2, s + 2 + 3 * i);

      // reset in the middle of a write ACCESS
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 32'h20, 32'h0000_1234);
      @(negedge clk);
      @(negedge clk);
      check("midrst_we_before", mem_we, 1'b1);
      #1 resetn = 1'b0;
      #1;
      check("midrst_we_async_drop", mem_we, 1'b0);
      check("midrst_state_async", fsm_state, 2'd0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 resetn = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_word8_kept", mem[8], 32'hCAFE_0008);
      check("midrst_state_idle", fsm_state, 2'd0);
      single(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_0008);

      // port 1 arrives during port 0 RESP and wins the next IDLE
      ack_port_q.delete();
      ack_cyc_q.delete();
      exp_q0.push_back({1'b0, 32'h0A0A_0A0A});
      exp_q1.push_back({1'b0, 32'h0B0B_0B0B});
      exp_q0.push_back({1'b0, 32'h0A0A_0A0A});
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h28, 32'h0);
      s = cyc;
      repeat (2) @(posedge clk);
      #1 drive(1, 1'b1, 1'b0, 32'h2C, 32'h0);
      repeat (4) @(posedge clk);
      #1 drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("late_ack_count", 64'(ack_port_q.size()), 64'd3);
      check_log("late0", 0, 0, s + 2);
      check_log("late1", 1, 1, s + 5);
      check_log("late2", 2, 0, s + 8);

      check("p0_queue_drained", 64'(exp_q0.size()), 64'd0);
      check("p1_queue_drained", 64'(exp_q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`dmem`: 32-bit `a`/`wd`/`rd`, `we`, word-indexed by `a[31:2]`, write committed on `posedge clk`) between two requesters.
  - Port 0: the CPU load/store path.
  - Port 1: the debug/loader port.
- Round-robin arbitration with a req/ack handshake and registered read data.
- Rejects misaligned and out-of-range accesses before they reach memory.
- Sits between the requesters and one `dmem` instance; `dmem` itself is unchanged.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached `dmem`; valid word index is 0..DEPTH-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req0  in  1  port-0 request; held high with `we0`/`addr0`/`wdata0` stable until `ack0` seen
- we0  in  1  port-0 write enable (1 = write, 0 = read)
- addr0  in  32  port-0 byte address
- wdata0  in  32  port-0 write data
- ack0  out  1  one-cycle completion pulse for port 0
- rdata0  out  32  port-0 read data, valid when `ack0` = 1, held until next port-0 completion
- err0  out  1  with `ack0`: access rejected (misaligned or out of range)
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1
- mem_a  out  32  to `dmem.a`
- mem_we  out  1  to `dmem.we`
- mem_wd  out  32  to `dmem.wd`
- mem_rd  in  32  from `dmem.rd` (combinational read)

Behaviour:
- Reset (`resetn` low, asynchronous):
  - state=IDLE, gnt=0, last=1 (port 0 wins the first tie).
  - ack0/ack1/err0/err1=0; rdata0/rdata1=0.
  - `mem_we` drops to 0 immediately (decoded from state).
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: gnt=that port; go to ACCESS.
  - Both req: gnt=~last; go to ACCESS.
- ACCESS (exactly one cycle):
  - `mem_a` = addr of gnt; `mem_wd` = wdata of gnt.
  - `mem_we` = we of gnt AND NOT bad.
  - bad = (addr[1:0] != 0) OR (addr[31:2] >= DEPTH), compared at full 30-bit width with no truncation.
  - At the closing edge:
    - The write commits in `dmem`.
    - Read, not bad: rdata_gnt <= `mem_rd`.
    - Bad: rdata_gnt <= 0 and err_gnt <= 1.
    - Write, not bad: rdata_gnt unchanged.
    - ack_gnt <= 1; last <= gnt; go to RESP.
- RESP (exactly one cycle):
  - ack_gnt and err_gnt high for this cycle only.
  - Always go to IDLE; requests are not sampled here.
  - Requester drops or changes req at the end of RESP.
- Outside ACCESS: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Latency:
  - req rises in cycle N (state IDLE) → ack in cycle N+2.
  - Minimum 3 cycles per access.
  - Back-to-back requests from one port are serviced every 3 cycles.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1…; neither port waits more than one access.
- A request arriving during ACCESS or RESP for the other port waits for IDLE.
- The ungranted port's inputs never reach memory; its ack stays 0.
- Dropping req before ack is a protocol violation; the arbiter still completes the latched access (no abort).
- Reset mid-ACCESS:
  - No write occurs, since `mem_we` clears before the edge.
  - No ack; all state returns to reset values.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Reset, then port 0 write: addr0=0x10, wdata0=0xDEADBEEF, req0 at cycle 1 → `mem_we`=1 and `mem_a`=0x10 in cycle 2; ack0 in cycle 3; err0=0; `dmem` word 4 = 0xDEADBEEF.
- Port 1 read of addr1=0x10 after that write → ack1 two cycles after req; rdata1=0xDEADBEEF, held after ack until the next port-1 completion.
- req0 and req1 held high together from reset, both reads of distinct preloaded words → acks ordered 0,1,0,1 at cycles 3,6,9,12; data matches each port's address.
- Misaligned write addr0=0x12, then out-of-range read addr1=0x100 (word 64, DEPTH=64) → `mem_we` stays 0 throughout; ack with err=1 and rdata=0; memory contents unchanged.
- resetn pulsed low mid-ACCESS of port-0 write addr0=0x20, wdata0=0x1234 → `mem_we` drops asynchronously; no ack0; word 8 unchanged; state IDLE; next request served normally.
- Port 0 requests continuously while port 1 makes a single request during port 0's RESP → port 1 granted at the next IDLE ahead of port 0 (last=0); port 1 completes within 3 cycles.
